// File: rtl/sram_frame_reader.sv
// Streams one raster frame out of a 16-bit SRAM, two reads per pixel, into a
// small FIFO that feeds a 30-bit RGB consumer. Yields the bus to the writer between pairs.
module sram_frame_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_writer_busy,
    input  logic [15:0] i_sram_dq,
    input  logic        i_pix_ready,
    output logic        o_sram_req,
    output logic        o_sram_oe_n,
    output logic [19:0] o_sram_addr,
    output logic        o_pix_valid,
    output logic [29:0] o_pix_rgb,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [18:0]   LAST_PIX = 19'(H_ACTIVE * V_ACTIVE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_RD_LO = 3'd2;
    localparam logic [2:0] S_RD_HI = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [18:0]   pix_q, pix_d;
    logic [14:0]   word0_q, word0_d;
    logic          und_q, und_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [29:0]   fifo_q [FIFO_DEPTH];
    logic          push, pop, empty, full;
    logic          unused_dq15;

    // Bit 15 of each SRAM word carries no colour information.
    assign unused_dq15 = i_sram_dq[15];

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);
    assign push  = (state_q == S_STORE);
    assign pop   = ~empty & i_pix_ready;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        word0_d = word0_q;
        und_d   = und_q;
        done_d  = 1'b0;
        if (i_pix_ready && state_q != S_IDLE && empty)
            und_d = 1'b1;
        case (state_q)
            S_IDLE: if (i_frame_start) begin
                pix_d   = '0;
                und_d   = 1'b0;
                state_d = S_WAIT;
            end
            // Only place the writer and FIFO space are checked; a started pair always completes.
            S_WAIT:  if (!i_writer_busy && !full) state_d = S_RD_LO;
            S_RD_LO: state_d = S_RD_HI;
            S_RD_HI: begin
                word0_d = i_sram_dq[14:0];
                state_d = S_STORE;
            end
            S_STORE: if (pix_q == LAST_PIX) begin
                state_d = S_DRAIN;
            end else begin
                pix_d   = pix_q + 19'd1;
                state_d = S_WAIT;
            end
            S_DRAIN: if (empty) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            word0_q <= '0;
            und_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            word0_q <= word0_d;
            und_q   <= und_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_q[wr_q] <= {word0_q, i_sram_dq[14:0]};
    end

    always_comb begin
        o_sram_addr = '0;
        case (state_q)
            S_RD_LO:         o_sram_addr = {pix_q, 1'b0};
            S_RD_HI, S_STORE: o_sram_addr = {pix_q, 1'b1};
            default:         o_sram_addr = '0;
        endcase
    end

    assign o_sram_req   = (state_q == S_RD_LO) || (state_q == S_RD_HI) || (state_q == S_STORE);
    assign o_sram_oe_n  = ~o_sram_req;
    assign o_pix_valid  = ~empty;
    assign o_pix_rgb    = fifo_q[rd_q];
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = done_q;
    assign o_underflow  = und_q;
endmodule

// File: tb/tb_sram_frame_reader.sv
// Randomized bench for sram_frame_reader on a reduced 16x4 frame with a one-cycle-latency SRAM model.
module tb_sram_frame_reader;
    localparam int H = 16, V = 4, D = 8, NPIX = H * V, MEMSZ = 2 * NPIX;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, wb = 1'b0, ready = 1'b0;
    logic [15:0] dq = '0;
    logic        o_sram_req, o_sram_oe_n, o_pix_valid, o_busy, o_frame_done, o_underflow;
    logic [19:0] o_sram_addr;
    logic [29:0] o_pix_rgb;
    logic [15:0] mem [MEMSZ];
    int tests = 0, fails = 0, exp_n = 0, done_cnt = 0;

    sram_frame_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(start), .i_writer_busy(wb),
        .i_sram_dq(dq), .i_pix_ready(ready), .o_sram_req(o_sram_req),
        .o_sram_oe_n(o_sram_oe_n), .o_sram_addr(o_sram_addr), .o_pix_valid(o_pix_valid),
        .o_pix_rgb(o_pix_rgb), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_underflow(o_underflow));

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data for the address seen at an edge appears after it.
    always_ff @(posedge clk) dq <= mem[int'(o_sram_addr) % MEMSZ];

    function automatic logic [29:0] exp_pix(int n);
        return {mem[2*n][14:0], mem[2*n+1][14:0]};
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < MEMSZ; i++)
            case (mode)
                0:       mem[i] = (i % 2 == 0) ? 16'h7C00 : 16'h7000;
                1:       mem[i] = 16'(i) & 16'h7FFF;
                default: mem[i] = 16'($urandom);
            endcase
    endtask

    task automatic start_frame();
        @(negedge clk); start = 1'b1; exp_n = 0; done_cnt = 0;
        @(negedge clk); start = 1'b0;
    endtask

    // Random consumer; every accepted pixel is compared with the raster model.
    task automatic consume(input int pct, input int stop_at);
        int cyc = 0;
        while (exp_n < stop_at && done_cnt == 0 && cyc < 20000) begin
            @(negedge clk); cyc++;
            ready = ($urandom_range(99) < pct);
            if (o_frame_done) done_cnt++;
            if (o_pix_valid && ready) begin
                tests++;
                if (exp_n >= NPIX) begin
                    fails++; $display("FAIL extra_pixel: got pixel %0d, frame has %0d", exp_n, NPIX);
                end else if (o_pix_rgb !== exp_pix(exp_n)) begin
                    fails++;
                    $display("FAIL pixel[%0d]: got %h expected %h", exp_n, o_pix_rgb, exp_pix(exp_n));
                end
                exp_n++;
            end
        end
        if (cyc >= 20000) begin
            tests++; fails++; $display("FAIL consume_timeout: got %0d pixels expected %0d", exp_n, stop_at);
        end
        @(negedge clk); ready = 1'b0;
        if (o_frame_done) done_cnt++;
    endtask

    task automatic end_checks(input string tag);
        repeat (5) begin @(negedge clk); if (o_frame_done) done_cnt++; end
        tests++; if (exp_n !== NPIX) begin fails++; $display("FAIL %s pix_count: got %0d expected %0d", tag, exp_n, NPIX); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt); end
        tests++; if (o_busy !== 1'b0 || o_sram_req !== 1'b0 || o_pix_valid !== 1'b0) begin
            fails++; $display("FAIL %s idle_after: busy=%b req=%b valid=%b expected 0 0 0", tag, o_busy, o_sram_req, o_pix_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (o_sram_req !== 1'b0 || o_sram_oe_n !== 1'b1 || o_sram_addr !== 20'd0 || o_pix_valid !== 1'b0 ||
            o_busy !== 1'b0 || o_frame_done !== 1'b0 || o_underflow !== 1'b0) begin
            fails++;
            $display("FAIL %s: req=%b oe_n=%b addr=%h valid=%b busy=%b done=%b und=%b expected 0 1 0 0 0 0 0",
                     tag, o_sram_req, o_sram_oe_n, o_sram_addr, o_pix_valid, o_busy, o_frame_done, o_underflow);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_latency_constant();
        fill(0);
        start_frame();
        tests++; if (o_sram_req !== 1'b0) begin fails++; $display("FAIL lat_c1_req: got %b expected 0", o_sram_req); end
        @(negedge clk);
        tests++; if (o_sram_req !== 1'b1 || o_sram_addr !== 20'd0) begin
            fails++; $display("FAIL lat_c2_rdlo: req=%b addr=%h expected 1 0", o_sram_req, o_sram_addr); end
        @(negedge clk);
        tests++; if (o_sram_addr !== 20'd1) begin fails++; $display("FAIL lat_c3_addr: got %h expected 1", o_sram_addr); end
        @(negedge clk);
        tests++; if (o_pix_valid !== 1'b0) begin fails++; $display("FAIL lat_c4_valid: got %b expected 0", o_pix_valid); end
        @(negedge clk);
        tests++; if (o_pix_valid !== 1'b1 || o_pix_rgb !== 30'h3E007000) begin
            fails++; $display("FAIL lat_c5_pixel: valid=%b rgb=%h expected 1 3e007000", o_pix_valid, o_pix_rgb); end
        consume(100, NPIX);
        end_checks("constant");
    endtask

    task automatic test_raster();
        fill(1);
        start_frame();
        consume(100, NPIX);
        end_checks("raster");
    endtask

    task automatic test_random_ready();
        fill(2);
        start_frame();
        consume(40, NPIX);
        end_checks("random_ready");
    endtask

    task automatic test_backpressure();
        int rises = 0;
        logic prev = 1'b0;
        fill(2);
        start_frame();
        repeat (100) begin
            @(negedge clk);
            if (o_sram_req && !prev) rises++;
            prev = o_sram_req;
        end
        tests++; if (rises !== D) begin fails++; $display("FAIL bp_pairs: got %0d expected %0d", rises, D); end
        tests++; if (o_sram_req !== 1'b0 || o_pix_valid !== 1'b1 || o_busy !== 1'b1) begin
            fails++; $display("FAIL bp_hold: req=%b valid=%b busy=%b expected 0 1 1", o_sram_req, o_pix_valid, o_busy); end
        consume(70, NPIX);
        end_checks("backpressure");
    endtask

    task automatic test_writer_busy();
        int hits = 0, k = 0;
        fill(2);
        wb = 1'b1;
        start_frame();
        repeat (20) begin @(negedge clk); if (o_sram_req) hits++; end
        tests++; if (hits !== 0) begin fails++; $display("FAIL wb_block: got %0d req cycles expected 0", hits); end
        wb = 1'b0;
        while (!o_sram_req && k < 4) begin @(negedge clk); k++; end
        tests++; if (o_sram_req !== 1'b1) begin fails++; $display("FAIL wb_release: got req=%b expected 1", o_sram_req); end
        k = 0;
        while (!(o_sram_req && o_sram_addr[0]) && k < 50) begin @(negedge clk); k++; end
        wb = 1'b1;
        @(negedge clk);
        tests++; if (o_sram_req !== 1'b1) begin fails++; $display("FAIL wb_pair_completes: got req=%b expected 1", o_sram_req); end
        hits = 0;
        repeat (10) begin @(negedge clk); if (o_sram_req) hits++; end
        tests++; if (hits !== 0) begin fails++; $display("FAIL wb_next_waits: got %0d req cycles expected 0", hits); end
        wb = 1'b0;
        consume(60, NPIX);
        end_checks("writer_busy");
    endtask

    task automatic test_underflow();
        fill(2);
        ready = 1'b1;
        start_frame();
        @(negedge clk);
        ready = 1'b0;
        tests++; if (o_underflow !== 1'b1) begin fails++; $display("FAIL und_set: got %b expected 1", o_underflow); end
        repeat (20) @(negedge clk);
        tests++; if (o_underflow !== 1'b1) begin fails++; $display("FAIL und_sticky: got %b expected 1", o_underflow); end
        consume(100, NPIX);
        end_checks("underflow");
        tests++; if (o_underflow !== 1'b1) begin fails++; $display("FAIL und_after_frame: got %b expected 1", o_underflow); end
        start_frame();
        tests++; if (o_underflow !== 1'b0) begin fails++; $display("FAIL und_clear: got %b expected 0", o_underflow); end
        consume(100, NPIX);
        end_checks("underflow2");
    endtask

    task automatic test_reset_midframe();
        fill(2);
        start_frame();
        consume(100, 20);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        repeat (3) begin @(negedge clk); if (o_frame_done) done_cnt++; end
        tests++; if (done_cnt !== 0) begin fails++; $display("FAIL midframe_no_done: got %0d expected 0", done_cnt); end
        rst_n = 1'b1;
        start_frame();
        @(negedge clk);
        tests++; if (o_sram_req !== 1'b1 || o_sram_addr !== 20'd0) begin
            fails++; $display("FAIL restart_addr: req=%b addr=%h expected 1 0", o_sram_req, o_sram_addr); end
        consume(100, NPIX);
        end_checks("restart");
    endtask

    initial begin
        test_reset();
        test_latency_constant();
        test_raster();
        test_random_ready();
        test_backpressure();
        test_writer_busy();
        test_underflow();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
